// File: rtl/apb_uart_rx.sv
// rtl/apb_uart_rx.sv - APB slave 8N1 UART receiver with a small receive FIFO
// Two registers: RXDATA (addr bit0=0, read pops) and STATUS (addr bit0=1, W1C flags).
module apb_uart_rx #(
   parameter int BUS_WIDTH    = 16,
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [BUS_WIDTH-1:0] S_PADDR,
   input  logic                 S_PWRITE,
   input  logic                 S_PSELx,
   input  logic                 S_PENABLE,
   input  logic [BUS_WIDTH-1:0] S_PWDATA,
   output logic [BUS_WIDTH-1:0] S_PRDATA,
   output logic                 S_PREADY,
   input  logic                 rx_wire,
   output logic                 rx_avail
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] HALF     = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
   localparam logic [PW:0]   FULL_CNT = (PW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic [7:0]      shift_q, shift_d;
   logic            sync1_q, rx_s_q;
   logic            push, frame_set;

   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [PW:0]     count_q, count_d;
   logic            overrun_q, overrun_d;
   logic            ferr_q, ferr_d;
   logic            rx_avail_q;

   logic            empty, full, pop, do_push, overrun_set, rd_access, st_write;
   logic            unused_ok;

   assign unused_ok = ^{S_PADDR[BUS_WIDTH-1:1], S_PWDATA[BUS_WIDTH-1:4], S_PWDATA[1:0]};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q   <= 1'b1;
         rx_s_q    <= 1'b1;
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
      end else begin
         sync1_q   <= rx_wire;
         rx_s_q    <= sync1_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (!rx_s_q) state_d = S_START;
         S_START: if (cnt_q == HALF) state_d = rx_s_q ? S_IDLE : S_DATA;
         S_DATA:  if (cnt_q == LAST && bit_idx_q == 3'd7) state_d = S_STOP;
         S_STOP:  if (cnt_q == LAST) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Counter, shifter and end-of-frame strobes; a glitchy start simply falls back to IDLE.
   always_comb begin
      cnt_d     = cnt_q + 1'b1;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      push      = 1'b0;
      frame_set = 1'b0;
      case (state_q)
         S_IDLE: cnt_d = '0;
         S_START: begin
            if (cnt_q == HALF) begin
               cnt_d     = '0;
               bit_idx_d = '0;
            end
         end
         S_DATA: begin
            if (cnt_q == LAST) begin
               cnt_d     = '0;
               shift_d   = {rx_s_q, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 1'b1;
            end
         end
         S_STOP: begin
            if (cnt_q == LAST) begin
               cnt_d     = '0;
               push      = rx_s_q;
               frame_set = !rx_s_q;
            end
         end
         default: cnt_d = '0;
      endcase
   end

   assign empty       = (count_q == '0);
   assign full        = (count_q == FULL_CNT);
   assign rd_access   = S_PSELx & S_PENABLE & !S_PWRITE & !S_PADDR[0];
   assign st_write    = S_PSELx & S_PENABLE & S_PWRITE & S_PADDR[0];
   assign pop         = rd_access & !empty;
   assign do_push     = push & (!full | pop);
   assign overrun_set = push & full & !pop;

   always_comb begin
      count_d = count_q;
      if (do_push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !do_push) count_d = count_q - 1'b1;
   end

   // Set beats a coincident write-1-to-clear.
   assign overrun_d = overrun_set | (overrun_q & !(st_write & S_PWDATA[2]));
   assign ferr_d    = frame_set   | (ferr_q    & !(st_write & S_PWDATA[3]));

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= shift_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overrun_q  <= 1'b0;
         ferr_q     <= 1'b0;
         rx_avail_q <= 1'b0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q    <= count_d;
         overrun_q  <= overrun_d;
         ferr_q     <= ferr_d;
         rx_avail_q <= (count_d != '0);
      end
   end

   assign rx_avail = rx_avail_q;
   assign S_PREADY = S_PSELx & S_PENABLE;

   always_comb begin
      S_PRDATA = '0;
      if (S_PSELx) begin
         if (S_PADDR[0]) begin
            S_PRDATA[0]    = !empty;
            S_PRDATA[1]    = full;
            S_PRDATA[2]    = overrun_q;
            S_PRDATA[3]    = ferr_q;
            S_PRDATA[15:8] = 8'(count_q);
         end else if (!empty) begin
            S_PRDATA[7:0] = mem_q[rd_ptr_q];
         end
      end
   end
endmodule

// File: tb/tb_apb_uart_rx.sv
// tb/tb_apb_uart_rx.sv - randomized self-checking bench for apb_uart_rx
// Reference model: byte queue plus two sticky flags, updated per whole frame / access.
module tb_apb_uart_rx;
   localparam int BW    = 16;
   localparam int CPB   = 16;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [BW-1:0] paddr = '0;
   logic          pwrite = 1'b0;
   logic          psel = 1'b0;
   logic          penable = 1'b0;
   logic [BW-1:0] pwdata = '0;
   logic [BW-1:0] prdata;
   logic          pready;
   logic          rx = 1'b1;
   logic          rx_avail;

   int            n_vec = 0;
   int            n_bad = 0;
   byte unsigned  mq[$];
   bit            m_ovr = 1'b0;
   bit            m_ferr = 1'b0;

   apb_uart_rx #(.BUS_WIDTH(BW), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .S_PADDR(paddr), .S_PWRITE(pwrite), .S_PSELx(psel),
      .S_PENABLE(penable), .S_PWDATA(pwdata), .S_PRDATA(prdata), .S_PREADY(pready),
      .rx_wire(rx), .rx_avail(rx_avail)
   );

   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_vec++;
      if (obs !== want) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, want);
      end
   endtask

   function automatic logic [15:0] m_status();
      logic [15:0] s;
      s       = '0;
      s[0]    = (mq.size() != 0);
      s[1]    = (mq.size() == DEPTH);
      s[2]    = m_ovr;
      s[3]    = m_ferr;
      s[15:8] = 8'(mq.size());
      return s;
   endfunction

   function automatic void m_frame(input logic [7:0] b, input logic stop_ok);
      if (!stop_ok)              m_ferr = 1'b1;
      else if (mq.size() == DEPTH) m_ovr = 1'b1;
      else                       mq.push_back(b);
   endfunction

   function automatic logic [15:0] m_pop();
      if (mq.size() == 0) return 16'h0;
      return {8'h00, mq.pop_front()};
   endfunction

   task automatic apb_read(input logic a, output logic [15:0] d);
      @(negedge clk);
      paddr = {{(BW-1){1'b0}}, a}; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
      #1 check("pready_setup", pready, 0);
      @(negedge clk);
      penable = 1'b1;
      #1 d = prdata;
      check("pready_access", pready, 1);
      @(negedge clk);
      psel = 1'b0; penable = 1'b0;
      #1 check("prdata_unselected", prdata, 0);
   endtask

   task automatic apb_write(input logic a, input logic [15:0] d);
      @(negedge clk);
      paddr = {{(BW-1){1'b0}}, a}; pwrite = 1'b1; pwdata = d; psel = 1'b1; penable = 1'b0;
      @(negedge clk);
      penable = 1'b1;
      @(negedge clk);
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic rd_data(input string tag);
      logic [15:0] d;
      logic [15:0] w;
      apb_read(1'b0, d);
      w = m_pop();
      check(tag, d, w);
   endtask

   task automatic rd_status(input string tag);
      logic [15:0] d;
      apb_read(1'b1, d);
      check(tag, d, m_status());
      check({tag, "_rx_avail"}, rx_avail, (mq.size() != 0));
   endtask

   task automatic wr_status(input logic [15:0] d);
      apb_write(1'b1, d);
      if (d[2]) m_ovr = 1'b0;
      if (d[3]) m_ferr = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      logic [9:0] bits;
      bits = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx = bits[i];
         repeat (CPB) @(negedge clk);
      end
      rx = 1'b1;
   endtask

   task automatic frame(input logic [7:0] b, input logic stop);
      send_frame(b, stop);
      repeat (CPB) @(negedge clk);
      m_frame(b, stop);
   endtask

   initial begin
      logic [15:0] rd;
      logic [7:0]  rb;
      logic        rs;
      logic [7:0]  pat;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_pready", pready, 0);
      check("rst_prdata", prdata, 0);
      check("rst_rx_avail", rx_avail, 0);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      rd_status("rst_status");

      // Single frame, RXDATA write ignored
      frame(8'hA5, 1'b1);
      rd_status("a5_status");
      apb_write(1'b0, 16'hFFFF);
      rd_status("a5_status_after_wr");
      rd_data("a5_data");
      rd_status("a5_status_empty");
      rd_data("empty_read");

      // Short low glitch, then a good frame
      @(negedge clk);
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      rd_status("glitch_status");
      frame(8'h3C, 1'b1);
      rd_data("3c_data");

      // Framing error and W1C
      frame(8'h55, 1'b0);
      rd_status("ferr_status");
      wr_status(16'h0008);
      rd_status("ferr_cleared");

      // Five back-to-back frames into a 4-deep FIFO
      @(negedge clk);
      for (int i = 1; i <= 5; i++) begin
         send_frame(8'(i), 1'b1);
         m_frame(8'(i), 1'b1);
      end
      repeat (CPB) @(negedge clk);
      rd_status("ovr_status");
      for (int i = 0; i < 4; i++) rd_data("ovr_data");
      wr_status(16'h0004);
      rd_status("ovr_cleared");

      // Full FIFO: pop lands on the same edge as the stop-bit push
      for (int i = 0; i < 4; i++) frame(8'($urandom), 1'b1);
      rd_status("full_status");
      pat = 8'($urandom);
      @(negedge clk);
      fork
         send_frame(pat, 1'b1);
         begin
            repeat (153) @(negedge clk);
            paddr = '0; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
            @(negedge clk);
            penable = 1'b1;
            #1 rd = prdata;
            @(negedge clk);
            psel = 1'b0; penable = 1'b0;
         end
      join
      check("coincide_data", rd, m_pop());
      mq.push_back(pat);
      repeat (CPB) @(negedge clk);
      rd_status("coincide_status");
      for (int i = 0; i < 4; i++) rd_data("coincide_drain");

      // Reset in the middle of data bit 4, with a byte already queued
      frame(8'h99, 1'b1);
      @(negedge clk);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx = i[0];
         repeat (CPB) @(negedge clk);
      end
      rx = 1'b1;
      repeat (CPB / 2) @(negedge clk);
      reset = 1'b0;
      #1 check("midrst_rx_avail", rx_avail, 0);
      check("midrst_pready", pready, 0);
      mq.delete();
      m_ovr = 1'b0;
      m_ferr = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      rd_status("midrst_status");
      frame(8'h7E, 1'b1);
      rd_status("7e_status");
      rd_data("7e_data");

      // Randomized traffic
      for (int it = 0; it < 16; it++) begin
         rb = 8'($urandom);
         rs = ($urandom_range(0, 7) != 0);
         frame(rb, rs);
         repeat ($urandom_range(0, 2)) rd_data("rnd_data");
         if ($urandom_range(0, 3) == 0) wr_status(16'($urandom));
         rd_status("rnd_status");
      end
      while (mq.size() != 0) rd_data("rnd_drain");
      rd_status("final_status");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
